// File: rtl/addr_signed_serial_ft_if.sv
// addr_signed_serial_ft_if: operand/result handshake bundle for the serial signed adder
interface addr_signed_serial_ft_if #(parameter int WIDTH = 8);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sat_en;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH:0]   sum;
  logic             ovf;
  modport master (output in_valid, a, b, sat_en, out_ready, input in_ready, out_valid, sum, ovf);
  modport slave  (input in_valid, a, b, sat_en, out_ready, output in_ready, out_valid, sum, ovf);
endinterface

// File: rtl/addr_signed_serial_ft.sv
// addr_signed_serial_ft: chunk-serial signed adder with saturation and duplicated chunk adder fault detection
module addr_signed_serial_ft #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  addr_signed_serial_ft_if.slave bus,
  output logic                 fault,
  input  logic                 fault_clr,
  input  logic                 fault_inj
);
  localparam int N  = WIDTH / CHUNK;
  localparam int CW = N > 1 ? $clog2(N) : 1;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic             sat_q, sat_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH:0]   sum_q, sum_d;
  logic             ovf_q, ovf_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             fault_q, fault_d;
  logic [CHUNK-1:0] ac, bc, sh_s;
  logic [CHUNK:0]   p;
  logic             sh_c, last, mism, full_ovf;
  logic [WIDTH-1:0] chunks;
  logic [WIDTH:0]   full, clamp;
  // primary chunk adder, ripple shadow adder, and final result assembly
  always_comb begin
    ac = a_q[cnt_q*CHUNK +: CHUNK];
    bc = b_q[cnt_q*CHUNK +: CHUNK];
    p = {1'b0, ac} + {1'b0, bc} + (CHUNK+1)'(carry_q);
    sh_c = carry_q;
    sh_s = '0;
    for (int i = 0; i < CHUNK; i++) begin
      sh_s[i] = ac[i] ^ bc[i] ^ sh_c;
      sh_c = (ac[i] & bc[i]) | (sh_c & (ac[i] | bc[i]));
    end
    sh_s[0] = sh_s[0] ^ fault_inj;
    mism = (state_q == CALC) && ({sh_c, sh_s} != p);
    chunks = sum_q[WIDTH-1:0];
    chunks[cnt_q*CHUNK +: CHUNK] = p[CHUNK-1:0];
    full = {a_q[WIDTH-1] ^ b_q[WIDTH-1] ^ p[CHUNK], chunks};
    full_ovf = full[WIDTH] ^ full[WIDTH-1];
    clamp = full[WIDTH] ? {2'b11, {(WIDTH-1){1'b0}}} : {2'b00, {(WIDTH-1){1'b1}}};
    last = cnt_q == CW'(N-1);
  end
  // FSM next state and registered handshake outputs
  always_comb begin
    state_d = state_q;
    a_d = a_q;
    b_d = b_q;
    sat_d = sat_q;
    cnt_d = cnt_q;
    carry_d = carry_q;
    sum_d = sum_q;
    ovf_d = ovf_q;
    in_ready_d = in_ready_q;
    out_valid_d = out_valid_q;
    fault_d = mism | (fault_q & ~fault_clr);
    if (state_q == IDLE && bus.in_valid) begin
      state_d = CALC;
      a_d = bus.a;
      b_d = bus.b;
      sat_d = bus.sat_en;
      cnt_d = '0;
      carry_d = 1'b0;
      in_ready_d = 1'b0;
    end
    if (state_q == CALC) begin
      carry_d = p[CHUNK];
      cnt_d = cnt_q + 1'b1;
      sum_d = !last ? {sum_q[WIDTH], chunks} : (sat_q && full_ovf) ? clamp : full;
      ovf_d = last ? full_ovf : ovf_q;
      state_d = last ? DONE : CALC;
      out_valid_d = last;
    end
    if (state_q == DONE && bus.out_ready) begin
      state_d = IDLE;
      out_valid_d = 1'b0;
      in_ready_d = 1'b1;
    end
  end
  // state registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q <= '0;
      b_q <= '0;
      sat_q <= 1'b0;
      cnt_q <= '0;
      carry_q <= 1'b0;
      sum_q <= '0;
      ovf_q <= 1'b0;
      in_ready_q <= 1'b1;
      out_valid_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      sat_q <= sat_d;
      cnt_q <= cnt_d;
      carry_q <= carry_d;
      sum_q <= sum_d;
      ovf_q <= ovf_d;
      in_ready_q <= in_ready_d;
      out_valid_q <= out_valid_d;
      fault_q <= fault_d;
    end
  end
  assign bus.in_ready = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.sum = sum_q;
  assign bus.ovf = ovf_q;
  assign fault = fault_q;
endmodule

// File: tb/tb_addr_signed_serial_ft.sv
// tb_addr_signed_serial_ft: directed and randomized checks of the serial signed adder
module tb_addr_signed_serial_ft;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic fault_clr = 1'b0;
  logic fault_inj = 1'b0;
  logic fault;
  int n_chk = 0;
  int n_fail = 0;
  addr_signed_serial_ft_if #(.WIDTH(8)) bus();
  addr_signed_serial_ft #(.WIDTH(8), .CHUNK(2)) dut (
    .clk(clk), .rst(rst), .bus(bus), .fault(fault), .fault_clr(fault_clr), .fault_inj(fault_inj)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic op(input string tag, input logic [7:0] ta, input logic [7:0] tb_v, input logic ts,
                    input logic [8:0] es, input logic eo, input int hold, input int inj, input logic clr);
    int n;
    chk({tag, "_in_ready"}, bus.in_ready, 1);
    bus.in_valid = 1'b1;
    bus.a = ta;
    bus.b = tb_v;
    bus.sat_en = ts;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    n = 0;
    while (!bus.out_valid && n < 20) begin
      fault_inj = (n == inj);
      fault_clr = clr && (n == inj);
      @(posedge clk); #1;
      if (n == inj) chk({tag, "_fault_edge"}, fault, 1);
      fault_inj = 1'b0;
      fault_clr = 1'b0;
      n++;
    end
    chk({tag, "_latency"}, n, 4);
    chk({tag, "_sum"}, bus.sum, es);
    chk({tag, "_ovf"}, bus.ovf, eo);
    for (int h = 0; h < hold; h++) begin
      bus.in_valid = 1'($urandom);
      bus.a = 8'($urandom);
      bus.b = 8'($urandom);
      @(posedge clk); #1;
      chk({tag, "_hold_sum"}, bus.sum, es);
      chk({tag, "_hold_valid"}, bus.out_valid, 1);
      chk({tag, "_hold_ready"}, bus.in_ready, 0);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk({tag, "_released"}, {bus.out_valid, bus.in_ready}, 2'b01);
  endtask
  initial begin
    logic [7:0] ra, rb;
    logic rs, ro;
    int x, y, s, e;
    bus.in_valid = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.sat_en = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_sum", bus.sum, 0);
    chk("rst_ovf", bus.ovf, 0);
    chk("rst_fault", fault, 0);
    @(negedge clk) rst = 1'b0;
    op("7f_01_full", 8'h7F, 8'h01, 1'b0, 9'h080, 1'b1, 0, -1, 1'b0);
    op("7f_01_sat", 8'h7F, 8'h01, 1'b1, 9'h07F, 1'b1, 0, -1, 1'b0);
    op("80_ff_sat", 8'h80, 8'hFF, 1'b1, 9'h180, 1'b1, 0, -1, 1'b0);
    op("80_ff_full", 8'h80, 8'hFF, 1'b0, 9'h17F, 1'b1, 0, -1, 1'b0);
    op("fb_03_full", 8'hFB, 8'h03, 1'b0, 9'h1FE, 1'b0, 0, -1, 1'b0);
    op("fb_03_sat_hold", 8'hFB, 8'h03, 1'b1, 9'h1FE, 1'b0, 10, -1, 1'b0);
    op("80_80_sat", 8'h80, 8'h80, 1'b1, 9'h180, 1'b1, 0, -1, 1'b0);
    op("7f_7f_full", 8'h7F, 8'h7F, 1'b0, 9'h0FE, 1'b1, 0, -1, 1'b0);
    chk("no_fault_yet", fault, 0);
    op("inj", 8'h10, 8'h20, 1'b0, 9'h030, 1'b0, 0, 1, 1'b0);
    chk("fault_set", fault, 1);
    op("after_inj", 8'h80, 8'h80, 1'b1, 9'h180, 1'b1, 0, -1, 1'b0);
    chk("fault_sticky", fault, 1);
    fault_clr = 1'b1;
    @(posedge clk); #1;
    fault_clr = 1'b0;
    chk("fault_clr", fault, 0);
    op("inj_clr", 8'h10, 8'h20, 1'b0, 9'h030, 1'b0, 0, 2, 1'b1);
    chk("set_wins", fault, 1);
    fault_clr = 1'b1;
    @(posedge clk); #1;
    fault_clr = 1'b0;
    chk("fault_clr2", fault, 0);
    bus.in_valid = 1'b1;
    bus.a = 8'h55;
    bus.b = 8'h11;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", bus.out_valid, 0);
    chk("midrst_in_ready", bus.in_ready, 1);
    chk("midrst_sum", bus.sum, 0);
    @(negedge clk) rst = 1'b0;
    op("after_rst", 8'h01, 8'h01, 1'b0, 9'h002, 1'b0, 0, -1, 1'b0);
    for (int k = 0; k < 2000; k++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rs = 1'($urandom);
      x = $signed(ra);
      y = $signed(rb);
      s = x + y;
      ro = (s > 127) || (s < -128);
      e = (rs && ro) ? ((s > 0) ? 127 : -128) : s;
      op("rand", ra, rb, rs, e[8:0], ro, $urandom_range(0, 3), -1, 1'b0);
    end
    chk("rand_fault", fault, 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
